// File: rtl/mem_responder_if.sv
// Bus bundle between a memory initiator and mem_responder.
// Carries request fields, write data, read data and the mov/moc handshake.
// The initiator holds mov until it sees moc; the responder holds moc until mov drops.
interface mem_responder_if;
    logic        ram_enable;
    logic        mov;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        moc;
    logic        err;

    modport master (
        output ram_enable, mov, rw, size, addr, data_in,
        input  data_out, moc, err
    );

    modport slave (
        input  ram_enable, mov, rw, size, addr, data_in,
        output data_out, moc, err
    );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressable big-endian memory responder behind a mov/moc handshake.
// Latency: moc rises WAIT_CYCLES edges after the accepting edge (0 = same edge).
// Backpressure: moc, err and data_out are held until the initiator drops mov.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int MEM_BYTES = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] dout_q, dout_d;
    logic        moc_q, moc_d;
    logic        err_q, err_d;
    // Low through reset and for the first edge after it, so no request is
    // taken before the first rising edge that sees reset released.
    logic        armed_q, armed_d;

    logic [7:0]  mem [MEM_BYTES];

    logic        commit;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_rw;
    logic [1:0]  acc_size;
    logic [2:0]  acc_bytes;
    logic [32:0] acc_last;
    logic        acc_err;
    logic [ADDR_W-1:0] idx [4];
    logic [7:0]  rd_byte [4];
    logic [31:0] rdata;
    logic [3:0]  lane_we;
    logic [7:0]  lane_wd [4];

    // Access seen at commit: live bus fields when committing straight from IDLE
    // (zero wait states), otherwise the fields latched at acceptance.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_rw    = rw_q;
        acc_size  = size_q;
        if (state_q == IDLE) begin
            acc_addr  = bus.addr;
            acc_wdata = bus.data_in;
            acc_rw    = bus.rw;
            acc_size  = bus.size;
        end

        case (acc_size)
            2'b00:   acc_bytes = 3'd1;
            2'b01:   acc_bytes = 3'd2;
            default: acc_bytes = 3'd4;
        endcase

        // Full 33-bit end address so a wrap past 2^32 still counts as out of range.
        acc_last = {1'b0, acc_addr} + 33'(acc_bytes) - 33'd1;
        acc_err  = (acc_size == 2'b11)
                 | ((acc_size == 2'b01) & acc_addr[0])
                 | ((acc_size == 2'b10) & (acc_addr[1:0] != 2'b00))
                 | (acc_last >= 33'(MEM_BYTES));

        for (int k = 0; k < 4; k++) begin
            idx[k]     = acc_addr[ADDR_W-1:0] + ADDR_W'(k);
            rd_byte[k] = mem[idx[k]];
        end

        // Big-endian: lowest address lands in the most significant used byte.
        case (acc_size)
            2'b00:   rdata = {24'h0, rd_byte[0]};
            2'b01:   rdata = {16'h0, rd_byte[0], rd_byte[1]};
            default: rdata = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        endcase
    end

    // Next-state and output logic for the IDLE/BUSY/DONE handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        size_d  = size_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        armed_d = 1'b1;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && bus.ram_enable && bus.mov) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.data_in;
                    rw_d    = bus.rw;
                    size_d  = bus.size;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.mov) begin
                    // Initiator withdrew: abandon without touching memory.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.mov) begin
                    state_d = IDLE;
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            moc_d  = 1'b1;
            err_d  = acc_err;
            dout_d = (acc_err || !acc_rw) ? 32'h0 : rdata;
        end
    end

    // Byte-lane write enables and data; rejected or reserved-size accesses write nothing.
    always_comb begin
        lane_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            lane_wd[k] = 8'h00;
        end
        case (acc_size)
            2'b00: begin
                lane_we    = 4'b0001;
                lane_wd[0] = acc_wdata[7:0];
            end
            2'b01: begin
                lane_we    = 4'b0011;
                lane_wd[0] = acc_wdata[15:8];
                lane_wd[1] = acc_wdata[7:0];
            end
            2'b10: begin
                lane_we    = 4'b1111;
                lane_wd[0] = acc_wdata[31:24];
                lane_wd[1] = acc_wdata[23:16];
                lane_wd[2] = acc_wdata[15:8];
                lane_wd[3] = acc_wdata[7:0];
            end
            default: lane_we = 4'b0000;
        endcase
        if (!(commit && !acc_rw && !acc_err)) begin
            lane_we = 4'b0000;
        end
    end

    // Control and datapath registers; reset clears everything except storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    // Storage is never reset; writes only happen on a committing edge.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                mem[idx[k]] <= lane_wd[k];
            end
        end
    end

    assign bus.data_out = dout_q;
    assign bus.moc      = moc_q;
    assign bus.err      = err_q;
endmodule
